// File: rtl/input_debounce_sync.sv
// input_debounce_sync: per-bit 2-flop sync + stability-count debounce.
// Ports:
//   clk          rising-edge clock
//   reset_n      async active-low reset
//   raw_in       raw switch/button levels (async to clk)
//   out_port     debounced levels (registered)
//   rise_pulse   one-cycle flag per bit on accepted 0->1
//   fall_pulse   one-cycle flag per bit on accepted 1->0
//   any_change   one-cycle OR of rise_pulse | fall_pulse
//   change_count cycles with any_change high (wraps)
module input_debounce_sync #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16,
  parameter int EVT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     raw_in,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     rise_pulse,
  output logic [WIDTH-1:0]     fall_pulse,
  output logic                 any_change,
  output logic [EVT_WIDTH-1:0] change_count
);

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] accept;
  logic             any_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign diff = sync2 ^ out_port;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    assign accept[g] = diff[g] && (cnt == LAST);

    // Counter only runs while the synced level disagrees
    // with the accepted level; it wraps to 0 on acceptance
    // or on any reversion, so it never passes LAST.
    always_comb begin
      cnt_nxt = '0;
      if (diff[g] && !accept[g])
        cnt_nxt = cnt + ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        cnt <= '0;
      else
        cnt <= cnt_nxt;
    end
  end

  assign any_acc = |accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port     <= '0;
      rise_pulse   <= '0;
      fall_pulse   <= '0;
      any_change   <= 1'b0;
      change_count <= '0;
    end else begin
      out_port     <= out_port ^ accept;
      rise_pulse   <= accept & sync2;
      fall_pulse   <= accept & ~sync2;
      any_change   <= any_acc;
      change_count <= change_count + EVT_WIDTH'(any_acc);
    end
  end

endmodule

// File: tb/tb_input_debounce_sync.sv
// tb_input_debounce_sync: directed checks of input_debounce_sync.
// STABLE_CYCLES=4, EVT_WIDTH=4 so wrap is reachable.
module tb_input_debounce_sync;

  localparam int W  = 8;
  localparam int SC = 4;
  localparam int EW = 4;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  raw_in;
  logic [W-1:0]  out_port;
  logic [W-1:0]  rise_pulse;
  logic [W-1:0]  fall_pulse;
  logic          any_change;
  logic [EW-1:0] change_count;

  int n_tests;
  int n_fail;
  logic [EW-1:0] ec;

  input_debounce_sync #(
    .WIDTH(W),
    .STABLE_CYCLES(SC),
    .CNT_WIDTH(16),
    .EVT_WIDTH(EW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
    .out_port(out_port),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change),
    .change_count(change_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect acceptance exactly at edge SC+2 of a held change.
  task automatic accept(input string tag,
                        input logic [W-1:0] nv,
                        input logic [W-1:0] old);
    raw_in = nv;
    for (int i = 1; i <= SC + 1; i++) begin
      step(1);
      chk({tag, "_hold"}, out_port, old);
    end
    step(1);
    ec = ec + 1'b1;
    chk({tag, "_out"}, out_port, nv);
    chk({tag, "_rise"}, rise_pulse, nv & ~old);
    chk({tag, "_fall"}, fall_pulse, ~nv & old);
    chk({tag, "_any"}, any_change, 1);
    chk({tag, "_cnt"}, change_count, ec);
    step(1);
    chk({tag, "_rise0"}, rise_pulse, 0);
    chk({tag, "_fall0"}, fall_pulse, 0);
    chk({tag, "_any0"}, any_change, 0);
    chk({tag, "_cnt1"}, change_count, ec);
  endtask

  initial begin
    logic seen;
    logic [W-1:0] cur;
    n_tests = 0;
    n_fail  = 0;
    ec      = '0;
    reset_n = 1'b0;
    raw_in  = '0;

    step(3);
    chk("rst_out", out_port, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_any", any_change, 0);
    chk("rst_cnt", change_count, 0);

    reset_n = 1'b1;
    accept("b0_rise", 8'h01, 8'h00);

    // Glitch on bit 3 held for only 3 cycles
    raw_in = 8'h09;
    step(3);
    raw_in = 8'h01;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (any_change || (out_port != 8'h01)) seen = 1'b1;
    end
    chk("glitch_seen", seen, 0);
    chk("glitch_out", out_port, 8'h01);
    chk("glitch_cnt", change_count, ec);

    accept("all_rise", 8'hFF, 8'h01);
    accept("all_fall", 8'h00, 8'hFF);
    accept("b7_rise", 8'h80, 8'h00);

    // Reset two cycles into a pending bit-0 change
    raw_in = 8'h81;
    step(2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", out_port, 0);
    chk("arst_cnt", change_count, 0);
    chk("arst_any", any_change, 0);
    ec = '0;
    step(2);
    reset_n = 1'b1;
    accept("rerst", 8'h81, 8'h00);

    // 16 accepted toggles on bit 0 wrap the 4-bit count
    cur = 8'h81;
    for (int i = 0; i < 16; i++) begin
      accept("tgl", cur ^ 8'h01, cur);
      cur = cur ^ 8'h01;
    end
    chk("wrap_cnt", change_count, 4'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
